// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeds a start/data/stop
// framing FSM whose bit time is a clock divider derived from CLKRATE/BAUDRATE.
module uart_tx_fifo #(
  parameter int CLKRATE  = 2_000_000,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int DIV = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_fifo: CLKRATE/BAUDRATE gives a bit divider below 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          tx_next;
  logic          busy_next;

  logic push;
  logic pop;
  logic has_data;
  logic bit_end;

  // Room is judged on the registered occupancy only, so a pop in the same
  // cycle never frees a slot for a simultaneous write.
  assign wr_ready = (level != FULL);
  assign push     = wr_valid & wr_ready;
  assign has_data = (level != '0);
  assign bit_end  = (baud_cnt == DIV_M1);

  // Framing FSM; the head of the FIFO is popped on leaving IDLE or at the end
  // of STOP, which lets queued bytes follow each other with no idle gap.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    tx_next       = tx;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (has_data) begin
          pop           = 1'b1;
          shift_next    = mem[rd_ptr];
          bit_idx_next  = '0;
          baud_cnt_next = '0;
          state_next    = START;
          tx_next       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          state_next    = DATA;
          tx_next       = shift[0];
        end else begin
          baud_cnt_next = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          shift_next    = shift >> 1;
          bit_idx_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next = shift[1];
          end
        end else begin
          baud_cnt_next = baud_cnt + CW'(1);
        end
      end
      default: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (has_data) begin
            pop          = 1'b1;
            shift_next   = mem[rd_ptr];
            bit_idx_next = '0;
            state_next   = START;
            tx_next      = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
    busy_next = (state_next != IDLE) | (level_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
      level    <= level_next;
      busy     <= busy_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_valid && !wr_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed framing/FIFO steps checked
// against an ideal 8N1 waveform, then random bytes through a UART receiver model.
module tb_uart_tx_fifo;

  localparam int CLKRATE  = 2_000_000;
  localparam int BAUDRATE = 9600;
  localparam int DEPTH    = 4;
  localparam int DIV      = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
  localparam int FRAME    = 10 * DIV;
  localparam int HIST     = 100000;
  localparam int NRAND    = 12;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [7:0]    wr_data  = 8'h00;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic       tx_hist   [0:HIST-1];
  logic       busy_hist [0:HIST-1];
  logic [7:0] stim_bytes [0:7];
  logic [7:0] rx_expect [$];

  uart_tx_fifo #(
    .CLKRATE (CLKRATE),
    .BAUDRATE(BAUDRATE),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .tx      (tx),
    .busy    (busy),
    .level   (level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Line history indexed by rising-edge number: entry n is the value after edge n.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) begin
    if (edge_cnt < HIST) begin
      tx_hist[edge_cnt]   <= tx;
      busy_hist[edge_cnt] <= busy;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitEdges(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  // Drives stim_bytes[0..n-1] on consecutive cycles; returns the edge that took the first.
  task automatic applyStimulus(input int n, output int first_edge);
    first_edge = -1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      wr_data  = stim_bytes[i];
      wr_valid = 1'b1;
      @(negedge clk);
      if (i == 0) first_edge = edge_cnt;
    end
    wr_valid = 1'b0;
  endtask

  // Compares the recorded line with back-to-back ideal frames of stim_bytes.
  task automatic checkWave(input string tag, input int start_edge, input int nbytes);
    int bad;
    int first_bad;
    logic [9:0] frame;
    bad       = 0;
    first_bad = -1;
    waitEdges(start_edge + nbytes * FRAME + 1);
    for (int k = 0; k < nbytes * FRAME; k++) begin
      frame = {1'b1, stim_bytes[k / FRAME], 1'b0};
      if (tx_hist[start_edge + k] !== frame[(k % FRAME) / DIV]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (tx_hist[start_edge + nbytes * FRAME] !== 1'b1) bad++;
    if (bad != 0) $display("[TB] %s first bad cycle offset %0d", tag, first_bad);
    checkOutput({tag, "_wave_bad_cycles"}, bad, 0);
  endtask

  initial begin
    int n;
    int e0;
    int lows;
    int frame_errs;

    // Reset state and a long quiet line.
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_wr_ready", wr_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst = 1'b0;
    e0 = edge_cnt;
    waitEdges(e0 + 5001);
    lows = 0;
    for (int k = 1; k <= 5000; k++) if (tx_hist[e0 + k] !== 1'b1) lows++;
    checkOutput("idle_tx_not_high", lows, 0);

    // Single byte 0x55 with exact bit timing and busy release.
    stim_bytes[0] = 8'h55;
    applyStimulus(1, n);
    checkOutput("single_level_after_write", level, 1);
    checkOutput("single_busy_after_write", busy, 1);
    checkOutput("single_tx_before_pop", tx, 1);
    checkWave("single", n + 1, 1);
    checkOutput("single_busy_last_stop", busy_hist[n + FRAME], 1);
    checkOutput("single_busy_after_frame", busy_hist[n + 1 + FRAME], 0);
    checkOutput("single_level_after_frame", level, 0);

    // Burst of six writes into a four-entry FIFO.
    for (int i = 0; i < 5; i++) stim_bytes[i] = 8'(i + 1);
    applyStimulus(5, n);
    checkOutput("burst_level_full", level, 4);
    checkOutput("burst_wr_ready_full", wr_ready, 0);
    checkOutput("burst_overflow_before", overflow, 0);
    wr_data  = 8'h06;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checkOutput("burst_overflow_set", overflow, 1);
    checkOutput("burst_level_after_reject", level, 4);
    checkWave("burst", n + 1, 5);
    checkOutput("burst_busy_after", busy_hist[n + 1 + 5 * FRAME], 0);
    checkOutput("burst_overflow_sticky", overflow, 1);

    // Boundary payloads.
    stim_bytes[0] = 8'h00;
    stim_bytes[1] = 8'hFF;
    applyStimulus(2, n);
    checkWave("boundary", n + 1, 2);

    // Reset during bit 3 of 0xA5 with two more bytes queued.
    stim_bytes[0] = 8'hA5;
    stim_bytes[1] = 8'h11;
    stim_bytes[2] = 8'h22;
    applyStimulus(3, n);
    checkOutput("midrst_level_queued", level, 2);
    waitEdges(n + 1 + 4 * DIV + DIV / 2);
    checkOutput("midrst_bit3_low", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tx", tx, 1);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_overflow", overflow, 0);
    checkOutput("midrst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    e0 = edge_cnt;
    waitEdges(e0 + 3 * DIV + 1);
    lows = 0;
    for (int k = 0; k <= 3 * DIV; k++) if (tx_hist[e0 + k] !== 1'b1) lows++;
    checkOutput("midrst_quiet_line", lows, 0);
    stim_bytes[0] = 8'h3C;
    applyStimulus(1, n);
    checkWave("post_reset", n + 1, 1);

    // Random bytes through a mid-bit sampling receiver, with flow control.
    frame_errs = 0;
    fork
      begin : writer
        int gap;
        int w;
        logic [7:0] b;
        for (int i = 0; i < NRAND; i++) begin
          gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME)) : 0;
          repeat (gap) @(negedge clk);
          @(negedge clk);
          w = 0;
          while (wr_ready !== 1'b1 && w < 3 * FRAME) begin
            @(negedge clk);
            w++;
          end
          if (wr_ready !== 1'b1) checkOutput("loop_wr_ready_timeout", wr_ready, 1);
          b        = 8'($urandom);
          wr_data  = b;
          wr_valid = 1'b1;
          rx_expect.push_back(b);
          @(negedge clk);
          wr_valid = 1'b0;
        end
      end
      begin : receiver
        int w;
        logic stop_rx;
        logic [7:0] rb;
        logic [7:0] eb;
        stop_rx = 1'b0;
        for (int i = 0; i < NRAND && !stop_rx; i++) begin
          w = 0;
          while (tx !== 1'b0 && w < 4 * FRAME) begin
            @(negedge clk);
            w++;
          end
          if (tx !== 1'b0) begin
            checkOutput("loop_start_timeout", tx, 0);
            stop_rx = 1'b1;
          end else begin
            repeat (DIV / 2) @(negedge clk);
            if (tx !== 1'b0) frame_errs++;
            for (int j = 0; j < 8; j++) begin
              repeat (DIV) @(negedge clk);
              rb[j] = tx;
            end
            repeat (DIV) @(negedge clk);
            if (tx !== 1'b1) frame_errs++;
            if (rx_expect.size() == 0) begin
              checkOutput("loop_unexpected_byte", 1, 0);
            end else begin
              eb = rx_expect.pop_front();
              checkOutput($sformatf("loop_byte%0d", i), rb, eb);
            end
          end
        end
      end
    join
    repeat (DIV) @(negedge clk);
    checkOutput("loop_framing_errors", frame_errs, 0);
    checkOutput("loop_bytes_left", rx_expect.size(), 0);
    checkOutput("loop_overflow", overflow, 0);
    checkOutput("loop_busy_end", busy, 0);
    checkOutput("loop_level_end", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
